// File: rtl/msrv32_mem_arbiter.sv
// Fetch/load-store arbiter for one AHB-Lite style memory port.
// Data has priority, a starvation counter protects fetch, and each data phase is tracked back to its owner.
module msrv32_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        i_req_in,
   input  logic [31:0] i_addr_in,
   output logic        i_gnt_out,
   output logic        i_ready_out,
   output logic [31:0] i_rdata_out,
   output logic        i_err_out,
   input  logic        d_req_in,
   input  logic        d_wr_in,
   input  logic [31:0] d_addr_in,
   input  logic [31:0] d_wdata_in,
   input  logic [3:0]  d_mask_in,
   output logic        d_gnt_out,
   output logic        d_ready_out,
   output logic [31:0] d_rdata_out,
   output logic        d_err_out,
   output logic [31:0] m_haddr_out,
   output logic [1:0]  m_htrans_out,
   output logic        m_hwrite_out,
   output logic [31:0] m_hwdata_out,
   output logic [3:0]  m_hwstrb_out,
   input  logic [31:0] m_hrdata_in,
   input  logic        m_hready_in,
   input  logic        m_hresp_in
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   owner_e          r_owner,  w_owner_nxt;
   logic            r_lock,   w_lock_nxt;
   logic            r_lock_d, w_lock_d_nxt;
   logic [CW-1:0]   r_starve, w_starve_nxt;
   logic [DW-1:0]   r_hwdata, w_hwdata_nxt;
   logic [SW-1:0]   r_hwstrb, w_hwstrb_nxt;

   logic            w_sel_i;
   logic            w_sel_d;
   logic            w_gnt_i;
   logic            w_gnt_d;
   logic            w_done;

   // State registers: phase owner, wait-state lock, starvation count, write-data phase
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_owner  <= OWN_NONE;
         r_lock   <= 1'b0;
         r_lock_d <= 1'b0;
         r_starve <= '0;
         r_hwdata <= '0;
         r_hwstrb <= '0;
      end else begin
         r_owner  <= w_owner_nxt;
         r_lock   <= w_lock_nxt;
         r_lock_d <= w_lock_d_nxt;
         r_starve <= w_starve_nxt;
         r_hwdata <= w_hwdata_nxt;
         r_hwstrb <= w_hwstrb_nxt;
      end
   end

   // Selection, bus address phase, data-phase return and next-state
   always_comb begin
      w_sel_i      = 1'b0;
      w_sel_d      = 1'b0;
      w_owner_nxt  = r_owner;
      w_lock_nxt   = r_lock;
      w_lock_d_nxt = r_lock_d;
      w_starve_nxt = r_starve;
      w_hwdata_nxt = r_hwdata;
      w_hwstrb_nxt = r_hwstrb;

      // Combinational outputs are gated by reset so they read as reset values immediately
      if (!rst_in) begin
         w_sel_i = 1'b0;
         w_sel_d = 1'b0;
      end else if (r_lock) begin
         w_sel_i = !r_lock_d;
         w_sel_d = r_lock_d;
      end else if (i_req_in && d_req_in) begin
         w_sel_i = (r_starve == LIMIT_C);
         w_sel_d = (r_starve != LIMIT_C);
      end else begin
         w_sel_i = i_req_in;
         w_sel_d = d_req_in;
      end

      w_gnt_i = w_sel_i && m_hready_in;
      w_gnt_d = w_sel_d && m_hready_in;
      w_done  = rst_in && m_hready_in;

      if (m_hready_in) begin
         w_owner_nxt  = w_gnt_d ? OWN_D : (w_gnt_i ? OWN_I : OWN_NONE);
         w_hwdata_nxt = (w_gnt_d && d_wr_in) ? d_wdata_in : '0;
         w_hwstrb_nxt = (w_gnt_d && d_wr_in) ? d_mask_in  : '0;
      end

      // A selection stalled by wait states is pinned until its grant
      if ((w_sel_i || w_sel_d) && !m_hready_in) begin
         w_lock_nxt   = 1'b1;
         w_lock_d_nxt = w_sel_d;
      end else if (w_gnt_i || w_gnt_d) begin
         w_lock_nxt   = 1'b0;
      end

      if (!i_req_in || w_gnt_i) begin
         w_starve_nxt = '0;
      end else if (w_gnt_d && (r_starve != LIMIT_C)) begin
         w_starve_nxt = r_starve + CW'(1);
      end
   end

   assign i_gnt_out    = w_gnt_i;
   assign d_gnt_out    = w_gnt_d;
   assign m_htrans_out = (w_sel_i || w_sel_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign m_haddr_out  = w_sel_d ? d_addr_in : (w_sel_i ? i_addr_in : AW'(0));
   assign m_hwrite_out = w_sel_d && d_wr_in;
   assign m_hwdata_out = r_hwdata;
   assign m_hwstrb_out = r_hwstrb;

   assign i_ready_out  = w_done && (r_owner == OWN_I);
   assign d_ready_out  = w_done && (r_owner == OWN_D);
   assign i_err_out    = i_ready_out && m_hresp_in;
   assign d_err_out    = d_ready_out && m_hresp_in;
   assign i_rdata_out  = m_hrdata_in;
   assign d_rdata_out  = m_hrdata_in;

endmodule
